// File: rtl/mem_access_pkg.sv
// Shared op codes, bus size codes, FSM states and helpers for the MEM stage.
package mem_access_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned STRB_W = 4;

    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_t;

    // Memory op held while its bus access is outstanding.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] waddr;
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] sdata;
        logic              flushed;
    } mem_op_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    // Unknown ops report byte size so an idle bus shows all-zero fields.
    function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SIZE_HALF;
            EXE_LW_OP, EXE_SW_OP:             return SIZE_WORD;
            default:                          return SIZE_BYTE;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return off[0];
            EXE_LW_OP, EXE_SW_OP:             return off != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data bus between the MEM stage (master) and memory (slave).
interface mem_access_if;
    import mem_access_pkg::*;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [WORD_W-1:0] data_addr;
    logic [STRB_W-1:0] data_wstrb;
    logic [WORD_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [WORD_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/mem_access_align.sv
// Load lane extract/extend and store strobe/lane replication.
module mem_access_align
    import mem_access_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        off,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] sdata,
    output logic [WORD_W-1:0] load_data,
    output logic [STRB_W-1:0] wstrb,
    output logic [WORD_W-1:0] wdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half out of the returned word.
    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend loads and shape store lanes.
    always_comb begin
        load_data = rdata;
        wstrb     = '0;
        wdata     = sdata;
        case (op)
            EXE_LB_OP:  load_data = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_data = {24'h0, byte_v};
            EXE_LH_OP:  load_data = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_data = {16'h0, half_v};
            EXE_SB_OP: begin
                wstrb = 4'b0001 << off;
                wdata = {4{sdata[7:0]}};
            end
            EXE_SH_OP: begin
                wstrb = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            EXE_SW_OP: wstrb = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs loads/stores on the data bus and registers the WB fields.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              whilo_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              stallreq_o,
    mem_access_if.master      bus,
    output logic [REG_AW-1:0] wb_waddr,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo,
    output logic              adel_o,
    output logic              ades_o,
    output logic [DATA_W-1:0] badvaddr_o
);

    mem_state_t        state;
    mem_op_t           lat;
    logic              req_q;
    logic [WORD_W-1:0] load_data;

    logic              take;
    logic              in_mem;
    logic              bad_align;
    logic              misal;
    logic              start;
    logic              bus_done;
    logic              keep_result;
    logic [WORD_W-1:0] eff_addr;

    // Decode the presented EX op.
    always_comb begin
        take      = valid_i && !flush_i;
        in_mem    = is_load(aluop_i) || is_store(aluop_i);
        bad_align = is_misaligned(aluop_i, mem_addr_i[1:0]);
        misal     = (CHECK_ALIGN != 0) && bad_align;
        start     = take && in_mem && !misal;
        eff_addr  = ((CHECK_ALIGN == 0) && bad_align) ? {mem_addr_i[31:2], 2'b00} : mem_addr_i;
    end

    // Bus completion and the result-write decision for the outstanding op.
    always_comb begin
        bus_done    = ((state == MEM_REQ) && bus.data_addr_ok && bus.data_data_ok) ||
                      ((state == MEM_WAIT) && bus.data_data_ok);
        keep_result = is_load(lat.op) && lat.we && !lat.flushed && !flush_i;
    end

    // Stall while an access is pending; released in the data_ok cycle.
    assign stallreq_o = !rst && (((state == MEM_IDLE) && start) ||
                                 ((state != MEM_IDLE) && !bus_done));

    mem_access_align u_align (
        .op        (lat.op),
        .off       (lat.addr[1:0]),
        .rdata     (bus.data_rdata),
        .sdata     (lat.sdata),
        .load_data (load_data),
        .wstrb     (bus.data_wstrb),
        .wdata     (bus.data_wdata)
    );

    assign bus.data_req  = req_q;
    assign bus.data_wr   = is_store(lat.op);
    assign bus.data_size = op_size(lat.op);
    assign bus.data_addr = lat.addr;

    // FSM, op latch and WB registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MEM_IDLE;
            lat        <= '0;
            req_q      <= 1'b0;
            wb_waddr   <= '0;
            wb_we      <= 1'b0;
            wb_wdata   <= '0;
            wb_hi      <= '0;
            wb_lo      <= '0;
            wb_whilo   <= 1'b0;
            adel_o     <= 1'b0;
            ades_o     <= 1'b0;
            badvaddr_o <= '0;
        end else begin
            adel_o <= 1'b0;
            ades_o <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (!take) begin
                        wb_we    <= 1'b0;
                        wb_whilo <= 1'b0;
                    end else if (!in_mem) begin
                        wb_waddr <= waddr_i;
                        wb_we    <= we_i;
                        wb_wdata <= wdata_i;
                        wb_hi    <= hi_i;
                        wb_lo    <= lo_i;
                        wb_whilo <= whilo_i;
                    end else if (misal) begin
                        adel_o     <= is_load(aluop_i);
                        ades_o     <= is_store(aluop_i);
                        badvaddr_o <= mem_addr_i;
                        wb_we      <= 1'b0;
                        wb_whilo   <= 1'b0;
                    end else begin
                        lat.op      <= aluop_i;
                        lat.waddr   <= waddr_i;
                        lat.we      <= we_i;
                        lat.addr    <= eff_addr;
                        lat.sdata   <= store_data_i;
                        lat.flushed <= 1'b0;
                        req_q       <= 1'b1;
                        wb_we       <= 1'b0;
                        wb_whilo    <= 1'b0;
                        state       <= MEM_REQ;
                    end
                end
                MEM_REQ, MEM_WAIT: begin
                    wb_we    <= 1'b0;
                    wb_whilo <= 1'b0;
                    if (flush_i) begin
                        lat.flushed <= 1'b1;
                    end
                    if ((state == MEM_REQ) && bus.data_addr_ok) begin
                        req_q <= 1'b0;
                        state <= MEM_WAIT;
                    end
                    if (bus_done) begin
                        wb_waddr <= lat.waddr;
                        wb_we    <= keep_result;
                        wb_wdata <= load_data;
                        state    <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the MEM stage with a scripted bus responder.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] ADDU_OP = 8'b0010_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [4:0]  waddr_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic        whilo_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        stallreq_o;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_if bus ();

    mem_access #(.DATA_W(32), .CHECK_ALIGN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .flush_i      (flush_i),
        .aluop_i      (aluop_i),
        .waddr_i      (waddr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .whilo_i      (whilo_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .stallreq_o   (stallreq_o),
        .bus          (bus),
        .wb_waddr     (wb_waddr),
        .wb_we        (wb_we),
        .wb_wdata     (wb_wdata),
        .wb_hi        (wb_hi),
        .wb_lo        (wb_lo),
        .wb_whilo     (wb_whilo),
        .adel_o       (adel_o),
        .ades_o       (ades_o),
        .badvaddr_o   (badvaddr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        valid_i = 1'b0;
        flush_i = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
    endtask

    // Present a memory op, answer addr_ok at cycle a_cyc and data_ok at d_cyc
    // (cycle 0 = presentation cycle), flush at f_cyc. Returns after the WB edge.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] wa, input logic [31:0] rdata,
                           input int a_cyc, input int d_cyc, input int f_cyc,
                           output int stalls, output logic [31:0] c_addr, output logic [3:0] c_strb,
                           output logic [31:0] c_wdata, output logic c_wr, output logic [1:0] c_size,
                           output logic c_req);
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; store_data_i = sdata;
        waddr_i = wa; we_i = 1'b1; whilo_i = 1'b1; wdata_i = 32'hDEAD_0000;
        stalls = 0; c_addr = '0; c_strb = '0; c_wdata = '0; c_wr = 1'b0; c_size = '0; c_req = 1'b0;
        for (int c = 0; c <= d_cyc; c++) begin
            bus.data_addr_ok = (c == a_cyc);
            bus.data_data_ok = (c == d_cyc);
            bus.data_rdata   = (c == d_cyc) ? rdata : 32'h0;
            flush_i          = (c == f_cyc);
            #1;
            if (stallreq_o) stalls++;
            if (c == a_cyc) begin
                c_req = bus.data_req; c_addr = bus.data_addr; c_strb = bus.data_wstrb;
                c_wdata = bus.data_wdata; c_wr = bus.data_wr; c_size = bus.data_size;
            end
            step();
        end
        go_idle();
    endtask

    int          st;
    logic [31:0] ca;
    logic [3:0]  cs;
    logic [31:0] cw;
    logic        cwr;
    logic [1:0]  csz;
    logic        crq;

    initial begin
        go_idle();
        #2;
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_req", 32'(bus.data_req), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'h0);
        check("rst_size", 32'(bus.data_size), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1: ALU op passes through with latency 1, no stall
        valid_i = 1'b1; aluop_i = ADDU_OP; wdata_i = 32'h1234_5678; we_i = 1'b1; waddr_i = 5'd5;
        whilo_i = 1'b1; hi_i = 32'h0000_00AA; lo_i = 32'h0000_00BB;
        #1;
        check("addu_stall", 32'(stallreq_o), 32'd0);
        step();
        check("addu_wdata", wb_wdata, 32'h1234_5678);
        check("addu_waddr", 32'(wb_waddr), 32'd5);
        check("addu_we", 32'(wb_we), 32'd1);
        check("addu_hi", wb_hi, 32'h0000_00AA);
        check("addu_whilo", 32'(wb_whilo), 32'd1);
        go_idle();
        step();
        check("bubble_we", 32'(wb_we), 32'd0);

        // 2: LB from byte 3, sign-extended; addr_ok on cycle 2, data_ok on cycle 4
        run_mem(EXE_LB_OP, 32'h0000_1003, 32'h0, 5'd7, 32'h80FF_0000, 2, 4, -1, st, ca, cs, cw, cwr, csz, crq);
        check("lb_req", 32'(crq), 32'd1);
        check("lb_size", 32'(csz), 32'd0);
        check("lb_addr", ca, 32'h0000_1003);
        check("lb_wr", 32'(cwr), 32'd0);
        check("lb_stalls", 32'(st), 32'd4);
        check("lb_wdata", wb_wdata, 32'hFFFF_FF80);
        check("lb_we", 32'(wb_we), 32'd1);
        check("lb_waddr", 32'(wb_waddr), 32'd7);
        check("lb_whilo", 32'(wb_whilo), 32'd0);
        check("lb_req_after", 32'(bus.data_req), 32'd0);

        // 3: SH to upper half, SB to byte 1
        run_mem(EXE_SH_OP, 32'h0000_2002, 32'h0000_ABCD, 5'd3, 32'h0, 1, 2, -1, st, ca, cs, cw, cwr, csz, crq);
        check("sh_strb", 32'(cs), 32'h0000_000C);
        check("sh_wdata", cw, 32'hABCD_ABCD);
        check("sh_wr", 32'(cwr), 32'd1);
        check("sh_size", 32'(csz), 32'd1);
        check("sh_we", 32'(wb_we), 32'd0);
        check("sh_stalls", 32'(st), 32'd2);
        run_mem(EXE_SB_OP, 32'h0000_1001, 32'h1234_565A, 5'd3, 32'h0, 1, 1, -1, st, ca, cs, cw, cwr, csz, crq);
        check("sb_strb", 32'(cs), 32'h0000_0002);
        check("sb_wdata", cw, 32'h5A5A_5A5A);
        check("sb_size", 32'(csz), 32'd0);

        // 4: misaligned LW then SW at 0x3001
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_3001; we_i = 1'b1;
        #1;
        check("lw_mis_stall", 32'(stallreq_o), 32'd0);
        step();
        check("lw_mis_adel", 32'(adel_o), 32'd1);
        check("lw_mis_ades", 32'(ades_o), 32'd0);
        check("lw_mis_bad", badvaddr_o, 32'h0000_3001);
        check("lw_mis_req", 32'(bus.data_req), 32'd0);
        check("lw_mis_we", 32'(wb_we), 32'd0);
        aluop_i = EXE_SW_OP;
        step();
        check("sw_mis_ades", 32'(ades_o), 32'd1);
        check("sw_mis_adel", 32'(adel_o), 32'd0);
        go_idle();
        step();
        check("ades_pulse", 32'(ades_o), 32'd0);

        // 5: LHU with addr_ok and data_ok together, then more loads
        run_mem(EXE_LHU_OP, 32'h0000_4002, 32'h0, 5'd8, 32'h8001_0000, 1, 1, -1, st, ca, cs, cw, cwr, csz, crq);
        check("lhu_wdata", wb_wdata, 32'h0000_8001);
        check("lhu_stalls", 32'(st), 32'd1);
        check("lhu_we", 32'(wb_we), 32'd1);
        run_mem(EXE_LH_OP, 32'h0000_6000, 32'h0, 5'd10, 32'h1234_8765, 1, 2, -1, st, ca, cs, cw, cwr, csz, crq);
        check("lh_wdata", wb_wdata, 32'hFFFF_8765);
        run_mem(EXE_LBU_OP, 32'h0000_6002, 32'h0, 5'd11, 32'h0090_0000, 1, 2, -1, st, ca, cs, cw, cwr, csz, crq);
        check("lbu_wdata", wb_wdata, 32'h0000_0090);
        run_mem(EXE_LW_OP, 32'h0000_5000, 32'h0, 5'd9, 32'hDEAD_BEEF, 1, 4, 2, st, ca, cs, cw, cwr, csz, crq);
        check("flush_stalls", 32'(st), 32'd4);
        check("flush_we", 32'(wb_we), 32'd0);
        check("flush_whilo", 32'(wb_whilo), 32'd0);

        // 6: async reset while in WAIT
        valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_8000; we_i = 1'b1;
        step();
        check("w_req", 32'(bus.data_req), 32'd1);
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0;
        #1;
        check("w_stall", 32'(stallreq_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_stall", 32'(stallreq_o), 32'd0);
        check("arst_req", 32'(bus.data_req), 32'd0);
        check("arst_wdata", wb_wdata, 32'h0);
        check("arst_addr", bus.data_addr, 32'h0);
        check("arst_bad", badvaddr_o, 32'h0);
        go_idle();
        step();
        rst = 1'b0;
        valid_i = 1'b1; aluop_i = ADDU_OP; wdata_i = 32'h0000_0042; waddr_i = 5'd2; we_i = 1'b1; whilo_i = 1'b0;
        #1;
        check("post_rst_stall", 32'(stallreq_o), 32'd0);
        step();
        check("post_rst_wdata", wb_wdata, 32'h0000_0042);
        go_idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
